sdr_app_req_gen: RTL and testbench

- Application-side request master that sits directly upstream of the SDRAM controller's application port.
- Accepts burst commands and write data from a host over valid/ready handshakes.
- Buffers each write burst completely, then drives the app_req/ack handshake and supplies write data on app_wr_next_req.
- Returns read beats to the host tagged with a last marker, and processes one outstanding burst at a time.

---
 rtl/sdr_app_pkg.sv | 25 ++
 rtl/sdr_app_wfifo.sv | 64 ++++++
 rtl/sdr_app_req_gen.sv | 190 +++++++++++++++++++
 tb/tb_sdr_app_req_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_app_pkg.sv
// Shared types and widths for the SDRAM application-side request generator.
// Consumed by the write FIFO and the top-level request FSM.
package sdr_app_pkg;

  localparam int APP_AW = 26;
  localparam int APP_DW = 32;
  localparam int APP_BW = 4;
  localparam int APP_RW = 9;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WDATA,
    REQ,
    WR_BURST,
    RD_BURST
  } appState_e;

  typedef struct packed {
    logic [APP_AW-1:0] addr;
    logic [APP_RW-1:0] len;
    logic              wrN;
    logic              wrap;
  } appCmd_t;

endpackage

// File: rtl/sdr_app_wfifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count.
// The head word reads as zero while the FIFO is empty so no stale data leaks out.
module sdr_app_wfifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 512
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        data_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [PW:0]      count_q;
  logic             pushEn;
  logic             popEn;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pushEn  = push_i & ~full_o;
  assign popEn   = pop_i & ~empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (popEn) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      case ({pushEn, popEn})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  underflowCheck: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop_i |-> !empty_o);

endmodule

// File: rtl/sdr_app_req_gen.sv
// Application request master for the SDRAM controller: buffers full write bursts,
// issues one app_req per burst, and forwards read beats to the host with a last flag.
module sdr_app_req_gen
  import sdr_app_pkg::*;
#(
  parameter int WF_DEPTH = 512
) (
  input  logic              sdram_clk,
  input  logic              reset_n,
  input  logic              sdr_init_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [APP_RW-1:0] cmd_len,
  input  logic              cmd_wr_n,
  input  logic              cmd_wrap,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [APP_DW-1:0] wdata,
  input  logic [APP_BW-1:0] wdata_be_n,
  output logic              app_req,
  output logic [APP_AW-1:0] app_req_addr,
  output logic [APP_RW-1:0] app_req_len,
  output logic              app_req_wr_n,
  output logic              app_req_wrap,
  input  logic              app_req_ack,
  input  logic              app_wr_next_req,
  output logic [APP_DW-1:0] app_wr_data,
  output logic [APP_BW-1:0] app_wr_en_n,
  input  logic              app_rd_valid,
  input  logic [APP_DW-1:0] app_rd_data,
  input  logic              app_last_rd,
  input  logic              app_last_wr,
  output logic              rd_valid,
  output logic [APP_DW-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err_len,
  output logic              busy
);

  localparam int FCW = $clog2(WF_DEPTH) + 1;
  localparam int BCW = APP_RW + 1;

  appState_e         state_q;
  appCmd_t           cmd_q;
  logic [BCW-1:0]    beatCnt_q;
  logic              appReq_q;
  logic              rdValid_q;
  logic [APP_DW-1:0] rdData_q;
  logic              rdLast_q;
  logic              done_q;
  logic              errLen_q;

  logic [APP_DW+APP_BW-1:0] fifoHead;
  logic [FCW-1:0]           fifoCount;
  logic                     fifoFull;
  logic                     fifoEmpty;
  logic                     cmdFire;
  logic [BCW-1:0]           beatNext;
  logic [BCW-1:0]           lenExt;
  logic                     burstActive;
  logic                     wrCountHit;
  logic                     wrDoneEvt;
  logic                     rdLastEvt;

  sdr_app_wfifo #(
    .WIDTH (APP_DW + APP_BW),
    .DEPTH (WF_DEPTH)
  ) wfifo (
    .clk_i   (sdram_clk),
    .rst_ni  (reset_n),
    .push_i  (wdata_valid),
    .pop_i   (app_wr_next_req),
    .data_i  ({wdata_be_n, wdata}),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // Reset is folded in so the host never sees ready while the block is held in reset.
  assign cmd_ready   = reset_n & sdr_init_done & (state_q == IDLE);
  assign cmdFire     = cmd_valid & cmd_ready;
  assign wdata_ready = ~fifoFull;
  assign app_wr_data = fifoHead[APP_DW-1:0];
  assign app_wr_en_n = fifoHead[APP_DW+APP_BW-1:APP_DW];

  assign beatNext    = beatCnt_q + BCW'(1);
  assign lenExt      = BCW'(cmd_q.len);
  assign burstActive = (state_q == REQ) || (state_q == WR_BURST) || (state_q == RD_BURST);
  assign wrCountHit  = app_wr_next_req && (beatNext == lenExt);
  assign wrDoneEvt   = app_last_wr || wrCountHit;
  assign rdLastEvt   = app_rd_valid && (app_last_rd || (beatNext == lenExt));

  assign app_req      = appReq_q;
  assign app_req_addr = cmd_q.addr;
  assign app_req_len  = cmd_q.len;
  assign app_req_wr_n = cmd_q.wrN;
  assign app_req_wrap = cmd_q.wrap;
  assign rd_valid     = rdValid_q;
  assign rd_data      = rdData_q;
  assign rd_last      = rdLast_q;
  assign done         = done_q;
  assign err_len      = errLen_q;
  assign busy         = (state_q != IDLE);

  // Beats are counted from REQ onward because the controller may start the data
  // phase in the same cycle it acknowledges; completion can therefore land in REQ.
  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      beatCnt_q <= '0;
      appReq_q  <= 1'b0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      rdLast_q  <= 1'b0;
      done_q    <= 1'b0;
      errLen_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      errLen_q  <= 1'b0;
      rdValid_q <= 1'b0;
      rdLast_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cmdFire) begin
            cmd_q <= '{addr: cmd_addr, len: cmd_len, wrN: cmd_wr_n, wrap: cmd_wrap};
            if (cmd_len == '0) begin
              errLen_q <= 1'b1;
            end else if (!cmd_wr_n) begin
              state_q <= WAIT_WDATA;
            end else begin
              state_q   <= REQ;
              appReq_q  <= 1'b1;
              beatCnt_q <= '0;
            end
          end
        end
        WAIT_WDATA: begin
          if (fifoCount >= FCW'(cmd_q.len)) begin
            state_q   <= REQ;
            appReq_q  <= 1'b1;
            beatCnt_q <= '0;
          end
        end
        REQ: begin
          if (app_req_ack) begin
            appReq_q <= 1'b0;
            state_q  <= cmd_q.wrN ? RD_BURST : WR_BURST;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase

      if (burstActive) begin
        if (!cmd_q.wrN) begin
          if (app_wr_next_req) begin
            beatCnt_q <= beatNext;
          end
          if (wrDoneEvt) begin
            done_q   <= 1'b1;
            appReq_q <= 1'b0;
            state_q  <= IDLE;
          end
        end else begin
          rdValid_q <= app_rd_valid;
          rdData_q  <= app_rd_data;
          if (app_rd_valid) begin
            beatCnt_q <= beatNext;
          end
          if (rdLastEvt) begin
            rdLast_q <= 1'b1;
            done_q   <= 1'b1;
            appReq_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
      end
    end
  end

  wrEndAgree: assert property (@(posedge sdram_clk) disable iff (!reset_n)
    (burstActive && !cmd_q.wrN && wrDoneEvt) |-> (app_last_wr == wrCountHit));

endmodule

// File: tb/tb_sdr_app_req_gen.sv
// Self-checking bench for sdr_app_req_gen: scenario tasks with a queue-based write
// data model and a one-beat-delay read model, plus randomized burst traffic.
module tb_sdr_app_req_gen;

  logic        sdram_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sdr_init_done = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [25:0] cmd_addr = '0;
  logic [8:0]  cmd_len = '0;
  logic        cmd_wr_n = 1'b0;
  logic        cmd_wrap = 1'b0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = '0;
  logic [3:0]  wdata_be_n = '0;
  logic        app_req;
  logic [25:0] app_req_addr;
  logic [8:0]  app_req_len;
  logic        app_req_wr_n;
  logic        app_req_wrap;
  logic        app_req_ack = 1'b0;
  logic        app_wr_next_req = 1'b0;
  logic [31:0] app_wr_data;
  logic [3:0]  app_wr_en_n;
  logic        app_rd_valid = 1'b0;
  logic [31:0] app_rd_data = '0;
  logic        app_last_rd = 1'b0;
  logic        app_last_wr = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        err_len;
  logic        busy;

  int assertCount = 0;
  int failCount = 0;

  always #5 sdram_clk = ~sdram_clk;

  sdr_app_req_gen dut (
    .sdram_clk       (sdram_clk),
    .reset_n         (reset_n),
    .sdr_init_done   (sdr_init_done),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .cmd_wr_n        (cmd_wr_n),
    .cmd_wrap        (cmd_wrap),
    .wdata_valid     (wdata_valid),
    .wdata_ready     (wdata_ready),
    .wdata           (wdata),
    .wdata_be_n      (wdata_be_n),
    .app_req         (app_req),
    .app_req_addr    (app_req_addr),
    .app_req_len     (app_req_len),
    .app_req_wr_n    (app_req_wr_n),
    .app_req_wrap    (app_req_wrap),
    .app_req_ack     (app_req_ack),
    .app_wr_next_req (app_wr_next_req),
    .app_wr_data     (app_wr_data),
    .app_wr_en_n     (app_wr_en_n),
    .app_rd_valid    (app_rd_valid),
    .app_rd_data     (app_rd_data),
    .app_last_rd     (app_last_rd),
    .app_last_wr     (app_last_wr),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .rd_last         (rd_last),
    .done            (done),
    .err_len         (err_len),
    .busy            (busy)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cycle();
    @(posedge sdram_clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks every output for its reset value, then releases.
  task automatic test_reset();
    cmd_valid = 0; wdata_valid = 0; app_req_ack = 0; app_wr_next_req = 0;
    app_rd_valid = 0; app_last_rd = 0; app_last_wr = 0;
    reset_n = 0;
    #2;
    assertCount++; if (cmd_ready !== 1'b0) begin failCount++; $display("[TB] FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    assertCount++; if (wdata_ready !== 1'b1) begin failCount++; $display("[TB] FAIL rst_wdata_ready: got %b want 1", wdata_ready); end
    assertCount++; if ({app_req, rd_valid, rd_last, done, err_len, busy} !== 6'b0) begin failCount++; $display("[TB] FAIL rst_flags: got %b want 000000", {app_req, rd_valid, rd_last, done, err_len, busy}); end
    assertCount++; if ({app_wr_data, app_wr_en_n, rd_data} !== 68'h0) begin failCount++; $display("[TB] FAIL rst_data: got %h want 0", {app_wr_data, app_wr_en_n, rd_data}); end
    cycle();
    cycle();
    assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL rst_no_done: got %b want 0", done); end
    reset_n = 1;
    cycle();
  endtask

  // Write burst: buffer len words, request, then pop. ackWithPop makes the ack coincide with pop 0.
  task automatic test_write_burst(input logic [25:0] addr, input int len, input int ackDelay, input bit ackWithPop);
    logic [35:0] wq[$];
    logic [35:0] w;
    logic        wrapExp;
    int          n;
    wrapExp = 1'($urandom);
    cmd_valid = 1; cmd_addr = addr; cmd_len = 9'(len); cmd_wr_n = 0; cmd_wrap = wrapExp;
    assertCount++; if (cmd_ready !== 1'b1) begin failCount++; $display("[TB] FAIL wr_cmd_ready: got %b want 1", cmd_ready); end
    cycle();
    cmd_valid = 0;
    for (int i = 0; i < len; i++) begin
      w = {4'($urandom), 32'($urandom)};
      wq.push_back(w);
      wdata_valid = 1; wdata = w[31:0]; wdata_be_n = w[35:32];
      assertCount++; if (app_req !== 1'b0) begin failCount++; $display("[TB] FAIL wr_req_early: got %b want 0 after %0d words", app_req, i); end
      cycle();
    end
    wdata_valid = 0;
    n = 0;
    while (app_req !== 1'b1 && n < 20) begin cycle(); n++; end
    assertCount++; if (app_req !== 1'b1) begin failCount++; $display("[TB] FAIL wr_req_timeout: got %b want 1", app_req); end
    assertCount++; if ({app_req_addr, app_req_len, app_req_wr_n, app_req_wrap} !== {addr, 9'(len), 1'b0, wrapExp}) begin
      failCount++; $display("[TB] FAIL wr_req_fields: got %h/%0d/%b/%b want %h/%0d/0/%b", app_req_addr, app_req_len, app_req_wr_n, app_req_wrap, addr, len, wrapExp);
    end
    repeat (ackDelay) begin
      cycle();
      assertCount++; if (app_req !== 1'b1) begin failCount++; $display("[TB] FAIL wr_req_hold: got %b want 1", app_req); end
    end
    if (!ackWithPop) begin
      app_req_ack = 1;
      cycle();
      app_req_ack = 0;
      assertCount++; if (app_req !== 1'b0) begin failCount++; $display("[TB] FAIL wr_req_drop: got %b want 0", app_req); end
    end
    for (int i = 0; i < len; i++) begin
      assertCount++; if ({app_wr_en_n, app_wr_data} !== wq[i]) begin failCount++; $display("[TB] FAIL wr_data[%0d]: got %h want %h", i, {app_wr_en_n, app_wr_data}, wq[i]); end
      app_wr_next_req = 1; app_last_wr = (i == len - 1); app_req_ack = ackWithPop && (i == 0);
      cycle();
      app_req_ack = 0;
      assertCount++; if (done !== (i == len - 1)) begin failCount++; $display("[TB] FAIL wr_done[%0d]: got %b want %b", i, done, (i == len - 1)); end
      if (ackWithPop && i == 0) begin
        assertCount++; if (app_req !== 1'b0) begin failCount++; $display("[TB] FAIL wr_req_drop_coinc: got %b want 0", app_req); end
      end
    end
    app_wr_next_req = 0; app_last_wr = 0;
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL wr_idle: got busy=%b want 0", busy); end
    cycle();
    assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL wr_done_once: got %b want 0", done); end
  endtask

  // Read burst: beats are expected back one cycle later. lastAt marks an early app_last_rd
  // (-1 for none), gapAfter inserts two idle cycles, abortAfter resets after that beat.
  task automatic test_read_burst(input logic [25:0] addr, input int len, input int gapAfter,
                                 input bit lastOnFinal, input int lastAt, input int abortAfter);
    logic [31:0] d;
    logic        lastExp;
    cmd_valid = 1; cmd_addr = addr; cmd_len = 9'(len); cmd_wr_n = 1; cmd_wrap = 0;
    assertCount++; if (cmd_ready !== 1'b1) begin failCount++; $display("[TB] FAIL rd_cmd_ready: got %b want 1", cmd_ready); end
    cycle();
    cmd_valid = 0;
    assertCount++; if ({app_req, app_req_addr, app_req_len, app_req_wr_n} !== {1'b1, addr, 9'(len), 1'b1}) begin
      failCount++; $display("[TB] FAIL rd_req: got %b/%h/%0d/%b want 1/%h/%0d/1", app_req, app_req_addr, app_req_len, app_req_wr_n, addr, len);
    end
    app_req_ack = 1;
    cycle();
    app_req_ack = 0;
    assertCount++; if ({app_req, rd_valid} !== 2'b00) begin failCount++; $display("[TB] FAIL rd_quiet: got req/rd_valid=%b want 00", {app_req, rd_valid}); end
    for (int b = 0; b < len; b++) begin
      if (b == gapAfter) begin
        app_rd_valid = 0; app_last_rd = 0;
        repeat (2) begin
          cycle();
          assertCount++; if (rd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL rd_gap: got %b want 0", rd_valid); end
        end
      end
      d = $urandom;
      lastExp = (b == len - 1) || (b == lastAt);
      app_rd_valid = 1; app_rd_data = d;
      app_last_rd = (lastOnFinal && b == len - 1) || (b == lastAt);
      cycle();
      assertCount++; if ({rd_valid, rd_data} !== {1'b1, d}) begin failCount++; $display("[TB] FAIL rd_beat[%0d]: got %b/%h want 1/%h", b, rd_valid, rd_data, d); end
      assertCount++; if ({rd_last, done} !== {lastExp, lastExp}) begin failCount++; $display("[TB] FAIL rd_last[%0d]: got last/done=%b want %b%b", b, {rd_last, done}, lastExp, lastExp); end
      if (b == abortAfter) begin
        test_reset();
        return;
      end
      if (lastExp) break;
    end
    app_rd_valid = 0; app_last_rd = 0;
    cycle();
    assertCount++; if ({rd_valid, done, busy} !== 3'b000) begin failCount++; $display("[TB] FAIL rd_end: got valid/done/busy=%b want 000", {rd_valid, done, busy}); end
  endtask

  // A zero-length command is dropped with a single err_len pulse.
  task automatic test_zero_len();
    cmd_valid = 1; cmd_addr = 26'h3ff; cmd_len = 0; cmd_wr_n = 0; cmd_wrap = 0;
    cycle();
    cmd_valid = 0;
    assertCount++; if ({err_len, busy, app_req, cmd_ready} !== 4'b1001) begin failCount++; $display("[TB] FAIL zlen_pulse: got err/busy/req/ready=%b want 1001", {err_len, busy, app_req, cmd_ready}); end
    cycle();
    assertCount++; if ({err_len, busy, app_req, cmd_ready} !== 4'b0001) begin failCount++; $display("[TB] FAIL zlen_after: got err/busy/req/ready=%b want 0001", {err_len, busy, app_req, cmd_ready}); end
  endtask

  // Commands wait for sdr_init_done and are accepted in the cycle it rises.
  task automatic test_init_gate();
    logic [31:0] d;
    sdr_init_done = 0;
    cmd_valid = 1; cmd_addr = 26'($urandom); cmd_len = 1; cmd_wr_n = 1; cmd_wrap = 0;
    #1;
    assertCount++; if (cmd_ready !== 1'b0) begin failCount++; $display("[TB] FAIL init_ready_low: got %b want 0", cmd_ready); end
    repeat (3) begin
      cycle();
      assertCount++; if ({app_req, busy} !== 2'b00) begin failCount++; $display("[TB] FAIL init_blocked: got req/busy=%b want 00", {app_req, busy}); end
    end
    sdr_init_done = 1;
    #1;
    assertCount++; if (cmd_ready !== 1'b1) begin failCount++; $display("[TB] FAIL init_ready_high: got %b want 1", cmd_ready); end
    cycle();
    cmd_valid = 0;
    assertCount++; if ({app_req, busy} !== 2'b11) begin failCount++; $display("[TB] FAIL init_accept: got req/busy=%b want 11", {app_req, busy}); end
    app_req_ack = 1;
    cycle();
    app_req_ack = 0;
    d = $urandom;
    app_rd_valid = 1; app_rd_data = d; app_last_rd = 1;
    cycle();
    app_rd_valid = 0; app_last_rd = 0;
    assertCount++; if ({rd_valid, rd_last, done, rd_data} !== {3'b111, d}) begin failCount++; $display("[TB] FAIL init_beat: got %b%b%b/%h want 111/%h", rd_valid, rd_last, done, rd_data, d); end
    cycle();
  endtask

  // Random mix of write and read bursts with random lengths, delays and data.
  task automatic test_random();
    int len;
    for (int k = 0; k < 4; k++) begin
      len = 1 + int'($urandom_range(0, 6));
      test_write_burst(26'($urandom), len, int'($urandom_range(0, 3)), 1'($urandom));
      len = 1 + int'($urandom_range(0, 6));
      test_read_burst(26'($urandom), len, int'($urandom_range(0, len - 1)), 1'($urandom),
                      (k == 2) ? int'($urandom_range(0, len - 1)) : -1, -1);
    end
  endtask

  initial begin
    sdr_init_done = 1;
    test_reset();
    test_write_burst(26'h100, 4, 3, 1'b0);
    test_read_burst(26'h2000, 8, 3, 1'b1, -1, -1);
    test_zero_len();
    test_init_gate();
    test_write_burst(26'h40, 2, 1, 1'b1);
    test_read_burst(26'h80, 8, 99, 1'b1, -1, 1);
    test_write_burst(26'h1234, 1, 0, 1'b0);
    test_read_burst(26'h55, 3, 99, 1'b0, -1, -1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
